// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, multi-cycle multiply stalls and branch flushes.
// Define HAZARD_PERF_CNT_EN to build the saturating stall-cycle counter behind stall_cnt_o.
module hazard_ctrl_unit #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ifid_rs_i,
    input  logic [4:0]  ifid_rt_i,
    input  logic        ifid_uses_rt_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rt_i,
    input  logic        mul_start_i,
    input  logic        branch_taken_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_flush_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MUL_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic       load_use;

    always_comb begin
        load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                   ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
    end

    // Priority: branch flush, then multiply occupancy, then load-use, then multiply launch.
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        state_d      = state_q;
        mul_cnt_d    = mul_cnt_q;

        if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            state_d      = RUN;
            mul_cnt_d    = 4'd0;
        end else begin
            case (state_q)
                MUL_BUSY: begin
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    idex_flush_o = 1'b1;
                    mul_cnt_d    = mul_cnt_q - 4'd1;
                    if (mul_cnt_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
                RUN, LU_STALL: begin
                    if (state_q == RUN && load_use) begin
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        idex_flush_o = 1'b1;
                        state_d      = LU_STALL;
                    end else if (mul_start_i && (MUL_LAT > 1)) begin
                        state_d   = MUL_BUSY;
                        mul_cnt_d = MUL_LOAD;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d   = RUN;
                    mul_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            mul_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_hazard_ctrl_unit;

    localparam int MUL_LAT = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  ifid_rs_i = '0;
    logic [4:0]  ifid_rt_i = '0;
    logic        ifid_uses_rt_i = 1'b0;
    logic        idex_memread_i = 1'b0;
    logic [4:0]  idex_rt_i = '0;
    logic        mul_start_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        ifid_flush_o;
    logic        idex_flush_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;

    hazard_ctrl_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .ifid_uses_rt_i (ifid_uses_rt_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .mul_start_i    (mul_start_i),
        .branch_taken_i (branch_taken_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_flush_o   (idex_flush_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        pc_write;
        logic        ifid_write;
        logic        ifid_flush;
        logic        idex_flush;
        logic [1:0]  state;
        logic [15:0] stall_cnt;
    } resp_t;

    resp_t exp_q[$];
    int    compared   = 0;
    int    mismatched = 0;

    // Reference model: remaining multiply stall cycles, a "just stalled on a load" flag, total stalls.
    int busy_left   = 0;
    bit after_lu    = 1'b0;
    int model_stall = 0;

    task automatic model_step(input logic memread, input logic [4:0] ex_rt, input logic [4:0] rs,
                              input logic [4:0] rt, input logic uses_rt, input logic mul,
                              input logic br, output resp_t r);
        bit lu;
        lu = memread && (ex_rt != 0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
        r.state      = (busy_left > 0) ? 2'd2 : (after_lu ? 2'd1 : 2'd0);
        r.stall_cnt  = PERF_EN ? 16'(model_stall) : 16'd0;
        r.pc_write   = 1'b1;
        r.ifid_write = 1'b1;
        r.ifid_flush = 1'b0;
        r.idex_flush = 1'b0;
        if (br) begin
            r.ifid_flush = 1'b1;
            r.idex_flush = 1'b1;
            busy_left    = 0;
            after_lu     = 1'b0;
        end else if (busy_left > 0) begin
            r.pc_write   = 1'b0;
            r.ifid_write = 1'b0;
            r.idex_flush = 1'b1;
            busy_left    = busy_left - 1;
        end else if (!after_lu && lu) begin
            r.pc_write   = 1'b0;
            r.ifid_write = 1'b0;
            r.idex_flush = 1'b1;
            after_lu     = 1'b1;
        end else begin
            after_lu = 1'b0;
            if (mul) busy_left = MUL_LAT - 1;
        end
        if (!r.pc_write && model_stall < 65535) model_stall = model_stall + 1;
    endtask

    task automatic applyStimulus(input logic memread, input logic [4:0] ex_rt, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic uses_rt, input logic mul,
                                 input logic br);
        resp_t r;
        @(posedge clk_i);
        #2;
        idex_memread_i = memread;
        idex_rt_i      = ex_rt;
        ifid_rs_i      = rs;
        ifid_rt_i      = rt;
        ifid_uses_rt_i = uses_rt;
        mul_start_i    = mul;
        branch_taken_i = br;
        model_step(memread, ex_rt, rs, rt, uses_rt, mul, br, r);
        exp_q.push_back(r);
    endtask

    // Reset is applied mid-cycle so its asynchronous effect is seen before the next edge.
    task automatic applyReset(input logic level);
        resp_t r;
        @(posedge clk_i);
        #2;
        rst_i          = level;
        idex_memread_i = 1'b0;
        idex_rt_i      = '0;
        ifid_rs_i      = '0;
        ifid_rt_i      = '0;
        ifid_uses_rt_i = 1'b0;
        mul_start_i    = 1'b0;
        branch_taken_i = 1'b0;
        if (level) begin
            busy_left   = 0;
            after_lu    = 1'b0;
            model_stall = 0;
        end
        model_step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, r);
        exp_q.push_back(r);
    endtask

    task automatic checkOutput();
        resp_t expv;
        resp_t act;
        expv           = exp_q.pop_front();
        act.pc_write   = pc_write_o;
        act.ifid_write = ifid_write_o;
        act.ifid_flush = ifid_flush_o;
        act.idex_flush = idex_flush_o;
        act.state      = state_o;
        act.stall_cnt  = stall_cnt_o;
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL cycle_resp #%0d at %0t: got pc=%0b ifw=%0b iff=%0b exf=%0b st=%0d cnt=%0d, expected pc=%0b ifw=%0b iff=%0b exf=%0b st=%0d cnt=%0d",
                     compared, $time, act.pc_write, act.ifid_write, act.ifid_flush, act.idex_flush,
                     act.state, act.stall_cnt, expv.pc_write, expv.ifid_write, expv.ifid_flush,
                     expv.idex_flush, expv.state, expv.stall_cnt);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) checkOutput();
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] r_ex, r_rs, r_rt;
        applyReset(1'b1);
        applyReset(1'b1);
        applyReset(1'b0);

        // Load-use on rs: one stall, masked second cycle, back to RUN
        applyStimulus(1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
        applyStimulus(1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        // No hazard on $zero
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        // rt path only counts when the instruction reads rt
        applyStimulus(1, 5'd5, 5'd1, 5'd5, 1, 0, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        applyStimulus(1, 5'd5, 5'd1, 5'd5, 0, 0, 0);
        // Multiply: three stall cycles then RUN, load-use ignored while busy
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        applyStimulus(1, 5'd3, 5'd3, 5'd0, 0, 1, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        // Branch in second multiply stall cycle
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        // Asynchronous reset mid-multiply
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        applyReset(1'b1);
        applyReset(1'b0);
        // One load-use plus one multiply from a clean counter
        applyStimulus(1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            r_ex = 5'($urandom_range(0, 3));
            r_rs = 5'($urandom_range(0, 3));
            r_rt = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                applyReset(1'b1);
                applyReset(1'b0);
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), r_ex, r_rs, r_rt, 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_i);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
